// File: rtl/spi_resp_pkg.sv
// Shared types and command-byte field positions for the SPI register responder.
package spi_resp_pkg;

    typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_t;

    localparam int         CMD_ADDR_MSB = 7;
    localparam int         CMD_ADDR_LSB = 3;
    localparam int         CMD_DIR_BIT  = 1;
    localparam logic [7:0] DUMMY_BYTE   = 8'h00;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin with registered-level
// rise/fall pulse outputs. RST_VAL should match the pin's idle level so reset release is edge-free.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  =  r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 slave bridging a command byte + data-byte stream onto register strobes.
// Define SPI_RESP_AUTO_INC_EN to make the register address advance after every data byte.
module spi_reg_responder
    import spi_resp_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              spi_ss_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              miso_oe,
    input  logic [7:0]        status_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              xfer_done
);

    logic w_sclk_rise, w_sclk_fall, w_sclk_lvl;
    logic w_ss_rise, w_ss_fall, w_ss_lvl;
    logic w_mosi, w_mosi_rise, w_mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .Clk(Clk), .Reset_n(Reset_n), .i_async(spi_sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .Clk(Clk), .Reset_n(Reset_n), .i_async(spi_ss_n),
        .o_level(w_ss_lvl), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .Clk(Clk), .Reset_n(Reset_n), .i_async(spi_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    spi_state_t        r_state;
    logic [7:0]        r_rx;
    logic [7:0]        r_tx;
    logic [7:0]        r_tx_next;
    logic [2:0]        r_bitcnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_dir;
    logic              r_boundary;
    logic              r_rd_wait;
    logic              r_rd_lat;

    logic [7:0]        w_rx_new;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic [ADDR_W-1:0] w_addr_next;

    assign w_rx_new   = {r_rx[6:0], w_mosi};
    assign w_cmd_addr = w_rx_new[CMD_ADDR_MSB -: ADDR_W];

`ifdef SPI_RESP_AUTO_INC_EN
    assign w_addr_next = r_addr + ADDR_W'(1);
`else
    assign w_addr_next = r_addr;
`endif

    assign spi_miso = r_tx[7];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= IDLE;
            r_rx       <= 8'h00;
            r_tx       <= 8'h00;
            r_tx_next  <= 8'h00;
            r_bitcnt   <= 3'd0;
            r_addr     <= '0;
            r_dir      <= 1'b0;
            r_boundary <= 1'b0;
            r_rd_wait  <= 1'b0;
            r_rd_lat   <= 1'b0;
            miso_oe    <= 1'b0;
            busy       <= 1'b0;
            xfer_done  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'h00;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
        end else begin
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            xfer_done <= 1'b0;
            // Two-cycle wait gives a registered register file a full cycle to answer.
            r_rd_wait <= 1'b0;
            r_rd_lat  <= r_rd_wait;
            if (r_rd_lat)
                r_tx_next <= rd_data;

            if (r_state == IDLE) begin
                if (w_ss_fall) begin
                    r_state    <= CMD;
                    r_tx       <= status_in;
                    r_rx       <= 8'h00;
                    r_bitcnt   <= 3'd0;
                    r_boundary <= 1'b0;
                    miso_oe    <= 1'b1;
                    busy       <= 1'b1;
                end
            end else begin
                if (w_sclk_rise) begin
                    r_rx     <= w_rx_new;
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (r_bitcnt == 3'd7) begin
                        r_boundary <= 1'b1;
                        if (r_state == CMD) begin
                            r_state <= DATA;
                            r_addr  <= w_cmd_addr;
                            r_dir   <= w_rx_new[CMD_DIR_BIT];
                            if (w_rx_new[CMD_DIR_BIT]) begin
                                r_tx_next <= DUMMY_BYTE;
                            end else begin
                                rd_en     <= 1'b1;
                                rd_addr   <= w_cmd_addr;
                                r_rd_wait <= 1'b1;
                            end
                        end else if (r_dir) begin
                            wr_en     <= 1'b1;
                            wr_addr   <= r_addr;
                            wr_data   <= w_rx_new;
                            r_addr    <= w_addr_next;
                            r_tx_next <= DUMMY_BYTE;
                        end else begin
                            rd_en     <= 1'b1;
                            rd_addr   <= w_addr_next;
                            r_addr    <= w_addr_next;
                            r_rd_wait <= 1'b1;
                        end
                    end
                end

                // First fall after a completed byte presents the prepared reply byte.
                if (w_sclk_fall) begin
                    if (r_boundary) begin
                        r_tx       <= r_tx_next;
                        r_boundary <= 1'b0;
                    end else begin
                        r_tx <= {r_tx[6:0], 1'b0};
                    end
                end

                // Deselect wins over everything except a strobe already issued this cycle.
                if (w_ss_rise) begin
                    r_state    <= IDLE;
                    r_rx       <= 8'h00;
                    r_tx       <= 8'h00;
                    r_bitcnt   <= 3'd0;
                    r_boundary <= 1'b0;
                    miso_oe    <= 1'b0;
                    busy       <= 1'b0;
                    xfer_done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench: an SPI master task drives transfers, expected strobes go into
// queues and a monitor pops/compares them as the responder emits them.
module tb_spi_reg_responder;

    localparam int ADDR_W = 5;
    localparam int HP     = 100;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic              spi_ss_n, spi_sclk, spi_mosi, spi_miso, miso_oe;
    logic [7:0]        status_in;
    logic              wr_en, rd_en, busy, xfer_done;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [7:0]        wr_data, rd_data;

    logic [7:0] mem [32];
    assign rd_data = mem[rd_addr];

    always #10 Clk = ~Clk;

    spi_reg_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .spi_ss_n(spi_ss_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .miso_oe(miso_oe), .status_in(status_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .xfer_done(xfer_done)
    );

    int n_checks = 0;
    int n_err    = 0;
    int exp_done = 0;
    logic [12:0] exp_wr[$];
    logic [4:0]  exp_rd[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (wr_en) begin
            if (exp_wr.size() == 0) chk("wr_en unexpected", {19'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            else chk("wr addr/data", {19'd0, wr_addr, wr_data}, {19'd0, exp_wr.pop_front()});
        end
        if (rd_en) begin
            if (exp_rd.size() == 0) chk("rd_en unexpected", {27'd0, rd_addr}, 32'hFFFF_FFFF);
            else chk("rd addr", {27'd0, rd_addr}, {27'd0, exp_rd.pop_front()});
        end
        if (xfer_done) begin
            if (exp_done == 0) chk("xfer_done unexpected", 32'd1, 32'd0);
            else begin
                exp_done--;
                chk("xfer_done", 32'd1, 32'd1);
            end
        end
    end

    task automatic ss_low();
        spi_ss_n = 1'b0;
        repeat (10) @(negedge Clk);
    endtask

    task automatic ss_high();
        #(HP);
        spi_ss_n = 1'b1;
        repeat (10) @(negedge Clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            #(HP);
            spi_sclk = 1'b1;
            r[i] = spi_miso;
            #(HP);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk(name, {busy, miso_oe, spi_miso, wr_en, rd_en, xfer_done, wr_addr, wr_data, rd_addr},
            32'd0);
    endtask

    logic [7:0] rx;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'hEE;
        mem[2] = 8'hC3;
        mem[3] = 8'h3C;
        Reset_n = 1'b0; spi_ss_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        status_in = 8'h5A;
        repeat (3) @(negedge Clk);
        chk_idle_outputs("reset outputs");
        Reset_n = 1'b1;
        repeat (5) @(negedge Clk);
        chk_idle_outputs("idle after reset");

        // Single write: addr 1 <- 0x1C, status byte returned during the command
        exp_wr.push_back({5'd1, 8'h1C});
        ss_low();
        chk("busy/oe on select", {30'd0, busy, miso_oe}, 32'd3);
        send_bits(8'h0A, 8, rx);
        chk("status byte", {24'd0, rx}, 32'h5A);
        send_bits(8'h1C, 8, rx);
        chk("write dummy reply", {24'd0, rx}, 32'h00);
        exp_done++;
        ss_high();
        chk("busy/oe after deselect", {30'd0, busy, miso_oe}, 32'd0);

        // Single read of addr 2; the reply byte must carry mem[2]
        exp_rd.push_back(5'd2);
`ifdef SPI_RESP_AUTO_INC_EN
        exp_rd.push_back(5'd3);
`else
        exp_rd.push_back(5'd2);
`endif
        ss_low();
        send_bits(8'h10, 8, rx);
        chk("status byte read cmd", {24'd0, rx}, 32'h5A);
        send_bits(8'h00, 8, rx);
        chk("read reply", {24'd0, rx}, 32'hC3);
        exp_done++;
        ss_high();

        // Burst write starting at the top register
        exp_wr.push_back({5'd31, 8'h11});
`ifdef SPI_RESP_AUTO_INC_EN
        exp_wr.push_back({5'd0, 8'h22});
`else
        exp_wr.push_back({5'd31, 8'h22});
`endif
        ss_low();
        send_bits(8'hFA, 8, rx);
        send_bits(8'h11, 8, rx);
        send_bits(8'h22, 8, rx);
        exp_done++;
        ss_high();

        // Abort after 5 data bits: no write, quick release of busy/oe
        ss_low();
        send_bits(8'h0A, 8, rx);
        send_bits(8'hFF, 5, rx);
        exp_done++;
        #(HP);
        spi_ss_n = 1'b1;
        repeat (4) @(posedge Clk);
        @(negedge Clk);
        chk("abort busy/oe", {30'd0, busy, miso_oe}, 32'd0);
        repeat (10) @(negedge Clk);

        exp_wr.push_back({5'd1, 8'h55});
        ss_low();
        send_bits(8'h0A, 8, rx);
        chk("status after abort", {24'd0, rx}, 32'h5A);
        send_bits(8'h55, 8, rx);
        exp_done++;
        ss_high();

        // Reset mid-byte, then SCLK activity with SS_n high
        ss_low();
        send_bits(8'h12, 3, rx);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk_idle_outputs("async reset mid-byte");
        spi_ss_n = 1'b1;
        spi_sclk = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        send_bits(8'h96, 8, rx);
        send_bits(8'h0A, 8, rx);
        repeat (10) @(negedge Clk);
        chk_idle_outputs("idle after SCLK with SS_n high");

        chk("pending writes", exp_wr.size(), 32'd0);
        chk("pending reads", exp_rd.size(), 32'd0);
        chk("pending xfer_done", exp_done, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
